// File: rtl/arith_pkg.sv
// Shared opcodes and IEEE-754 single-precision constants for the execute-stage arithmetic unit.
// No logic; pure definitions.
// Imported by arithmetic_unit and fp_add_sub.
package arith_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_MULU = 3'b100;
  localparam logic [2:0] OP_FADD = 3'b101;
  localparam logic [2:0] OP_FSUB = 3'b110;
  localparam logic [2:0] OP_FMUL = 3'b111;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // Signed 10 bits so exponent arithmetic can go below zero or past 255 without wrapping.
  localparam logic signed [9:0] FP_BIAS = 10'sd127;
  localparam logic [31:0]       FP_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fp_add_sub.sv
// Single-precision add/subtract with truncation; denormal inputs flushed to zero.
// Purely combinational (zero latency).
// No handshake; result follows inputs.
module fp_add_sub
  import arith_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] res_o
);

  logic                 sa, sb, sx, sy, a_big, found;
  logic [FP_EXP_W-1:0]  ea, eb, ex, ey, d;
  logic [FP_MAN_W:0]    ma, mb, mx, my, my_al, norm;
  logic [FP_MAN_W+1:0]  sum;
  logic [4:0]           lz;
  logic signed [9:0]    e_res;
  logic                 unused_norm;

  assign unused_norm = norm[FP_MAN_W];

  // Order operands by magnitude, align, add/sub magnitudes, renormalise and pack.
  always_comb begin
    sa    = a_i[31];
    sb    = b_i[31] ^ sub_i;
    ea    = a_i[30:23];
    eb    = b_i[30:23];
    ma    = (ea == '0) ? '0 : {1'b1, a_i[22:0]};
    mb    = (eb == '0) ? '0 : {1'b1, b_i[22:0]};
    a_big = {ea, ma} >= {eb, mb};
    sx    = a_big ? sa : sb;
    sy    = a_big ? sb : sa;
    ex    = a_big ? ea : eb;
    ey    = a_big ? eb : ea;
    mx    = a_big ? ma : mb;
    my    = a_big ? mb : ma;
    d     = ex - ey;
    my_al = (d >= 8'd25) ? '0 : (my >> d);
    sum   = (sx == sy) ? ({1'b0, mx} + {1'b0, my_al}) : ({1'b0, mx} - {1'b0, my_al});

    lz    = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(23 - i);
        found = 1'b1;
      end
    end

    if (sum[24]) begin
      norm  = sum[24:1];
      e_res = $signed({2'b00, ex}) + 10'sd1;
    end else begin
      norm  = sum[23:0] << lz;
      e_res = $signed({2'b00, ex}) - $signed({5'b00000, lz});
    end

    if (ea == 8'hFF || eb == 8'hFF) begin
      res_o = FP_QNAN;
    end else if (sum == '0) begin
      res_o = 32'h0;
    end else if (e_res <= 10'sd0) begin
      res_o = {sx, 31'h0};
    end else if (e_res >= 10'sd255) begin
      res_o = {sx, 8'hFF, 23'h0};
    end else begin
      res_o = {sx, e_res[7:0], norm[22:0]};
    end
  end

endmodule

// File: rtl/arithmetic_unit.sv
// Execute-stage integer/FP arithmetic unit, 32-bit operands, 64-bit registered result.
// Latency 1 cycle: a/b/op sampled at a rising edge appear on out after that edge.
// No backpressure; a new operation is accepted every cycle.
module arithmetic_unit
  import arith_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [63:0] out
);

  logic [63:0]        out_q, out_d;
  logic [32:0]        add_w, sub_w;
  logic [63:0]        mul_w;
  logic [31:0]        fadd_w, fmul_w;
  logic               fm_s;
  logic [23:0]        fm_ma, fm_mb;
  logic [47:0]        fm_p;
  logic signed [9:0]  fm_e;
  logic [22:0]        fm_man;
  logic               unused_fm_bits;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign mul_w = 64'(a) * 64'(b);
  assign unused_fm_bits = ^fm_p[22:0];

  fp_add_sub u_fp_add_sub (
    .a_i   (a),
    .b_i   (b),
    .sub_i (op == OP_FSUB),
    .res_o (fadd_w)
  );

  // FP multiply: 24x24 significand product, one-bit normalise, truncate, clamp exponent.
  always_comb begin
    fm_s  = a[31] ^ b[31];
    fm_ma = {1'b1, a[22:0]};
    fm_mb = {1'b1, b[22:0]};
    fm_p  = fm_ma * fm_mb;
    fm_e  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - FP_BIAS;
    if (fm_p[47]) begin
      fm_man = fm_p[46:24];
      fm_e   = fm_e + 10'sd1;
    end else begin
      fm_man = fm_p[45:23];
    end

    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      fmul_w = FP_QNAN;
    end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      fmul_w = {fm_s, 31'h0};
    end else if (fm_e <= 10'sd0) begin
      fmul_w = {fm_s, 31'h0};
    end else if (fm_e >= 10'sd255) begin
      fmul_w = {fm_s, 8'hFF, 23'h0};
    end else begin
      fmul_w = {fm_s, fm_e[7:0], fm_man};
    end
  end

  // Select the result for the current opcode.
  always_comb begin
    out_d = '0;
    case (op)
      OP_ADD:  out_d = {31'h0, add_w};
      OP_SUB:  out_d = {{31{sub_w[32]}}, sub_w};
      OP_SLT:  out_d = {63'h0, $signed(a) < $signed(b)};
      OP_SLTU: out_d = {63'h0, a < b};
      OP_MULU: out_d = mul_w;
      OP_FADD: out_d = {32'h0, fadd_w};
      OP_FSUB: out_d = {32'h0, fadd_w};
      OP_FMUL: out_d = {32'h0, fmul_w};
      default: out_d = '0;
    endcase
  end

  // Single result register; reset wins over any opcode.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_arithmetic_unit.sv
module tb_arithmetic_unit;
  import arith_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic [63:0] out;

  int checks = 0;
  int errors = 0;

  arithmetic_unit dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .op  (op),
    .out (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] mask;
    logic [63:0] e;
  } vec_t;

  // Reference FP add: signed significands, align smaller magnitude (truncating), sum, normalise by loops.
  function automatic logic [31:0] m_fadd(logic [31:0] x, logic [31:0] y);
    int     ex, ey, e, d;
    longint mx, my, vx, vy, s, mag, t;
    logic   sg;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return 32'h7FC00000;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 0 : ((longint'(1) << 23) | longint'(x[22:0]));
    my = (ey == 0) ? 0 : ((longint'(1) << 23) | longint'(y[22:0]));
    if (ex < ey || (ex == ey && mx < my)) begin
      d = ex; ex = ey; ey = d;
      t = mx; mx = my; my = t;
      sg = x[31]; x[31] = y[31]; y[31] = sg;
    end
    d  = ex - ey;
    my = (d >= 25) ? 0 : (my >> d);
    vx = x[31] ? -mx : mx;
    vy = y[31] ? -my : my;
    s  = vx + vy;
    if (s == 0) return 32'h0;
    sg  = (s < 0);
    mag = sg ? -s : s;
    e   = ex;
    while (mag >= (longint'(1) << 24)) begin mag = mag >> 1; e++; end
    while (mag <  (longint'(1) << 23)) begin mag = mag << 1; e--; end
    if (e <= 0)   return {sg, 31'h0};
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    return {sg, e[7:0], mag[22:0]};
  endfunction

  // Reference FP multiply: full product scaled down by loop until 24 significant bits remain.
  function automatic logic [31:0] m_fmul(logic [31:0] x, logic [31:0] y);
    int     ex, ey, e;
    longint p;
    logic   sg;
    sg = x[31] ^ y[31];
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return 32'h7FC00000;
    if (x[30:23] == 8'h00 || y[30:23] == 8'h00) return {sg, 31'h0};
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    p  = ((longint'(1) << 23) | longint'(x[22:0])) * ((longint'(1) << 23) | longint'(y[22:0]));
    e  = ex + ey - 127 - 23;
    while (p >= (longint'(1) << 24)) begin p = p >> 1; e++; end
    if (e <= 0)   return {sg, 31'h0};
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    return {sg, e[7:0], p[22:0]};
  endfunction

  function automatic logic [63:0] model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    case (o)
      OP_ADD:  return 64'(sx + sy);
      OP_SUB:  return 64'(sx - sy);
      OP_SLT:  return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      OP_SLTU: return (x < y) ? 64'd1 : 64'd0;
      OP_MULU: return 64'(x) * 64'(y);
      OP_FADD: return {32'h0, m_fadd(x, y)};
      OP_FSUB: return {32'h0, m_fadd(x, {~y[31], y[30:0]})};
      default: return {32'h0, m_fmul(x, y)};
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int r;
    r = $urandom_range(0, 99);
    if (r < 8)       e = 8'h00;
    else if (r < 13) e = 8'hFF;
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_int();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // One operation per cycle: drive at a falling edge, sample one full cycle later.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] got);
    @(negedge clk);
    op = o; a = x; b = y;
    @(negedge clk);
    got = out;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = OP_ADD; a = 32'hFFFFFFFF; b = 32'h1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out !== 64'h0) begin
        errors++;
        $display("FAIL reset_edge%0d got=%h exp=%h", i, out, 64'h0);
      end
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out !== 64'h1_00000000) begin
      errors++;
      $display("FAIL first_after_reset got=%h exp=%h", out, 64'h1_00000000);
    end
    rst = 1'b1; op = OP_MULU;
    @(negedge clk);
    checks++;
    if (out !== 64'h0) begin
      errors++;
      $display("FAIL reset_priority got=%h exp=%h", out, 64'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic [63:0] got;
    v.push_back('{"add_nocarry", OP_ADD,  32'hF0F0F0FF, 32'h0F0F0F00, 64'hFFFFFFFFFFFFFFFF, 64'h00000000FFFFFFFF});
    v.push_back('{"add_carry",   OP_ADD,  32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFFFFFFFFFF, 64'h0000000100000000});
    v.push_back('{"sub_pos",     OP_SUB,  32'd23,       32'd11,       64'hFFFFFFFFFFFFFFFF, 64'd12});
    v.push_back('{"sub_neg",     OP_SUB,  32'd11,       32'd23,       64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF4});
    v.push_back('{"slt",         OP_SLT,  32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFFFFFFFFFF, 64'd1});
    v.push_back('{"sltu",        OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFFFFFFFFFF, 64'd0});
    v.push_back('{"mulu_small",  OP_MULU, 32'd11111,    32'd10,       64'hFFFFFFFFFFFFFFFF, 64'h1B206});
    v.push_back('{"mulu_max",    OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFE00000001});
    v.push_back('{"fadd_1_23",   OP_FADD, 32'h3F800000, 32'h41B80000, 64'hFFFFFFFFFFFFFFFF, 64'h41C00000});
    v.push_back('{"fsub_cancel", OP_FSUB, 32'h40000000, 32'h40000000, 64'hFFFFFFFFFFFFFFFF, 64'h0});
    v.push_back('{"fmul_neg",    OP_FMUL, 32'hBFE00000, 32'hBFC00000, 64'hFFFFFFFFFFFFFFFF, 64'h40280000});
    v.push_back('{"fmul_inf",    OP_FMUL, 32'h7F000000, 32'h7F000000, 64'hFFFFFFFFFFFFFFFF, 64'h7F800000});
    v.push_back('{"fmul_nan",    OP_FMUL, 32'h7F800000, 32'h3F800000, 64'hFFFFFFFFFFFFFFFF, 64'h7FC00000});
    v.push_back('{"fadd_nan",    OP_FADD, 32'h3F800000, 32'hFF800000, 64'hFFFFFFFFFFFFFFFF, 64'h7FC00000});
    v.push_back('{"fmul_uflow",  OP_FMUL, 32'h80800000, 32'h00800000, 64'hFFFFFFFFFFFFFFFF, 64'h80000000});
    v.push_back('{"fadd_denorm", OP_FADD, 32'h3F800000, 32'h00400000, 64'hFFFFFFFFFFFFFFFF, 64'h3F800000});
    v.push_back('{"fadd_farsh",  OP_FADD, 32'h4C000000, 32'h3F800000, 64'hFFFFFFFFFFFFFFFF, 64'h4C000000});
    foreach (v[i]) begin
      run_op(v[i].o, v[i].x, v[i].y, got);
      checks++;
      if ((got & v[i].mask) !== v[i].e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", v[i].name, got, v[i].e);
      end
    end
  endtask

  task automatic test_random_int();
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [63:0] got, e;
    for (int i = 0; i < 300; i++) begin
      o = 3'($urandom_range(0, 4));
      x = rand_int();
      y = rand_int();
      e = model(o, x, y);
      run_op(o, x, y, got);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rand_int op=%0d a=%h b=%h got=%h exp=%h", o, x, y, got, e);
      end
    end
  endtask

  task automatic test_random_fp();
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [63:0] got, e;
    int          ey;
    for (int i = 0; i < 400; i++) begin
      o = 3'($urandom_range(5, 7));
      x = rand_fp();
      case ($urandom_range(0, 3))
        0: y = {~x[31], x[30:0]};
        1: begin
             ey = int'(x[30:23]) + $urandom_range(0, 6) - 3;
             if (ey < 1) ey = 1;
             if (ey > 254) ey = 254;
             y = {1'($urandom), ey[7:0], 23'($urandom)};
           end
        default: y = rand_fp();
      endcase
      e = model(o, x, y);
      run_op(o, x, y, got);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rand_fp op=%0d a=%h b=%h got=%h exp=%h", o, x, y, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] expq[$];
    logic [63:0] e;
    @(negedge clk);
    for (int i = 0; i < 61; i++) begin
      if (i > 0) begin
        e = expq.pop_front();
        checks++;
        if (out !== e) begin
          errors++;
          $display("FAIL back_to_back idx=%0d got=%h exp=%h", i - 1, out, e);
        end
      end
      if (i < 60) begin
        op = 3'($urandom);
        a  = (op >= OP_FADD) ? rand_fp() : rand_int();
        b  = (op >= OP_FADD) ? rand_fp() : rand_int();
        expq.push_back(model(op, a, b));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    logic [63:0] e1, e2;
    @(negedge clk);
    op = OP_MULU; a = 32'h12345678; b = 32'h9ABCDEF0;
    e1 = model(OP_MULU, 32'h12345678, 32'h9ABCDEF0);
    e2 = model(OP_SUB, 32'h1, 32'h2);
    @(posedge clk); #1;
    op = OP_SUB; a = 32'h1; b = 32'h2;
    #2;
    checks++;
    if (out !== e1) begin
      errors++;
      $display("FAIL hold_between_edges got=%h exp=%h", out, e1);
    end
    @(negedge clk);
    checks++;
    if (out !== e1) begin
      errors++;
      $display("FAIL hold_at_negedge got=%h exp=%h", out, e1);
    end
    @(negedge clk);
    checks++;
    if (out !== e2) begin
      errors++;
      $display("FAIL hold_next_edge got=%h exp=%h", out, e2);
    end
  endtask

  initial begin
    rst = 1'b1; op = OP_ADD; a = '0; b = '0;
    test_reset();
    test_directed();
    test_random_int();
    test_random_fp();
    test_back_to_back();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
